// File: rtl/fetch_buffer_pkg.sv
// fetch_buffer_pkg: shared constants, entry type and pop clamp for the fetch issue buffer.
package fetch_buffer_pkg;

    localparam int DEFAULT_DEPTH   = 8;
    localparam int DEFAULT_PC_W    = 10;
    localparam int DEFAULT_INSTR_W = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef struct packed {
        logic [DEFAULT_PC_W-1:0]    pc;
        logic [DEFAULT_INSTR_W-1:0] instr;
    } entry_t;

    // Decode may ask for more than is present; it only ever gets what exists.
    function automatic logic [1:0] clamp_pop(input logic [1:0] issue, input int unsigned occ);
        return (occ < 32'(issue)) ? occ[1:0] : issue;
    endfunction

endpackage

// File: rtl/fb_storage.sv
// fb_storage: DEPTH-entry register file with two writes at consecutive addresses
// and two asynchronous reads at consecutive addresses.
module fb_storage #(
    parameter int DEPTH = 8,
    parameter int W     = 42,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we_1,
    input  logic          i_we_2,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata_1,
    input  logic [W-1:0]  i_wdata_2,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata_1,
    output logic [W-1:0]  o_rdata_2
);

    logic [W-1:0] r_mem [DEPTH];

    always_comb begin
        o_rdata_1 = r_mem[i_raddr];
        o_rdata_2 = r_mem[i_raddr + AW'(1)];
    end

    always_ff @(posedge clk) begin
        if (i_we_1) r_mem[i_waddr] <= i_wdata_1;
        if (i_we_2) r_mem[i_waddr + AW'(1)] <= i_wdata_2;
    end

endmodule

// File: rtl/fetch_issue_buffer.sv
// fetch_issue_buffer: dual-in/dual-out decoupling queue between fetch and decode,
// with show-ahead outputs, registered back-pressure and flush on branch correction.
module fetch_issue_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int PC_W    = 10,
    parameter int INSTR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid_1,
    input  logic                 in_valid_2,
    input  logic [INSTR_W-1:0]   in_instr_1,
    input  logic [INSTR_W-1:0]   in_instr_2,
    input  logic [PC_W-1:0]      in_pc_1,
    input  logic [PC_W-1:0]      in_pc_2,
    output logic                 hold,
    input  logic [1:0]           issue_count,
    output logic                 out_valid_1,
    output logic                 out_valid_2,
    output logic [INSTR_W-1:0]   out_instr_1,
    output logic [INSTR_W-1:0]   out_instr_2,
    output logic [PC_W-1:0]      out_pc_1,
    output logic [PC_W-1:0]      out_pc_2,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = PC_W + INSTR_W;

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [1:0]    w_push;
    logic [1:0]    w_pop;
    logic [EW-1:0] w_rd_1;
    logic [EW-1:0] w_rd_2;

    // hold depends only on registered occupancy, so fetch sees no combinational loop.
    always_comb begin
        hold        = r_count > CW'(DEPTH - 2);
        w_push      = (hold || flush || !in_valid_1) ? 2'd0 : (in_valid_2 ? 2'd2 : 2'd1);
        w_pop       = clamp_pop(issue_count, 32'(r_count));
        count       = r_count;
        out_valid_1 = r_count != '0;
        out_valid_2 = r_count >= CW'(2);
        out_pc_1    = out_valid_1 ? w_rd_1[EW-1:INSTR_W] : '0;
        out_pc_2    = out_valid_2 ? w_rd_2[EW-1:INSTR_W] : '0;
        out_instr_1 = out_valid_1 ? w_rd_1[INSTR_W-1:0] : INSTR_W'(NOP_INSTR);
        out_instr_2 = out_valid_2 ? w_rd_2[INSTR_W-1:0] : INSTR_W'(NOP_INSTR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_pop);
            r_tail  <= r_tail + AW'(w_push);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    fb_storage #(.DEPTH(DEPTH), .W(EW), .AW(AW)) u_storage (
        .clk      (clk),
        .i_we_1   (w_push != 2'd0),
        .i_we_2   (w_push == 2'd2),
        .i_waddr  (r_tail),
        .i_wdata_1({in_pc_1, in_instr_1}),
        .i_wdata_2({in_pc_2, in_instr_2}),
        .i_raddr  (r_head),
        .o_rdata_1(w_rd_1),
        .o_rdata_2(w_rd_2)
    );

endmodule

// File: tb/tb_fetch_issue_buffer.sv
// tb_fetch_issue_buffer: random and directed stimulus against an occupancy model,
// with a scoreboard of accepted instructions checked by an independent issue monitor.
module tb_fetch_issue_buffer;
    import fetch_buffer_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 0, rst = 1, flush = 0;
    logic        in_valid_1 = 0, in_valid_2 = 0;
    logic [31:0] in_instr_1 = 0, in_instr_2 = 0;
    logic [9:0]  in_pc_1 = 0, in_pc_2 = 0;
    logic [1:0]  issue_count = 0;
    logic        hold, out_valid_1, out_valid_2;
    logic [31:0] out_instr_1, out_instr_2;
    logic [9:0]  out_pc_1, out_pc_2;
    logic [3:0]  count;

    int     compared = 0, mismatched = 0, mcount = 0;
    entry_t sb[$];
    logic [9:0] nextpc = 0;

    fetch_issue_buffer #(.DEPTH(DEPTH), .PC_W(10), .INSTR_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid_1(in_valid_1), .in_valid_2(in_valid_2),
        .in_instr_1(in_instr_1), .in_instr_2(in_instr_2),
        .in_pc_1(in_pc_1), .in_pc_2(in_pc_2),
        .hold(hold), .issue_count(issue_count),
        .out_valid_1(out_valid_1), .out_valid_2(out_valid_2),
        .out_instr_1(out_instr_1), .out_instr_2(out_instr_2),
        .out_pc_1(out_pc_1), .out_pc_2(out_pc_2),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ins_of(input logic [9:0] pc);
        return ({22'h0, pc} * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    task automatic check_state();
        chk("count", 64'(count), 64'(mcount));
        chk("hold", 64'(hold), 64'(mcount > DEPTH - 2));
        chk("valid1", 64'(out_valid_1), 64'(mcount >= 1));
        chk("valid2", 64'(out_valid_2), 64'(mcount >= 2));
        if (mcount < 1) begin
            chk("pc1_idle", 64'(out_pc_1), 0);
            chk("instr1_idle", 64'(out_instr_1), 0);
        end
        if (mcount < 2) begin
            chk("pc2_idle", 64'(out_pc_2), 0);
            chk("instr2_idle", 64'(out_instr_2), 0);
        end
    endtask

    task automatic step(input logic v1, input logic v2, input logic [9:0] p1, input logic [9:0] p2,
                        input logic [31:0] i1, input logic [31:0] i2, input logic [1:0] ic,
                        input logic fl, output int pushed);
        int pop;
        in_valid_1 = v1; in_valid_2 = v2; in_pc_1 = p1; in_pc_2 = p2;
        in_instr_1 = i1; in_instr_2 = i2; issue_count = ic; flush = fl;
        @(negedge clk);
        check_state();
        @(posedge clk);
        pushed = (fl || mcount > DEPTH - 2 || !v1) ? 0 : (v2 ? 2 : 1);
        pop = (int'(ic) < mcount) ? int'(ic) : mcount;
        if (fl) begin
            mcount = 0;
            sb.delete();
        end else begin
            mcount += pushed - pop;
            if (pushed >= 1) sb.push_back('{pc: p1, instr: i1});
            if (pushed == 2) sb.push_back('{pc: p2, instr: i2});
        end
        #1;
    endtask

    // Fetch re-presents the same pair until it is taken, so PCs advance only by what was accepted.
    task automatic gen(input logic v1, input logic v2, input logic [1:0] ic, input logic fl);
        int p;
        step(v1, v2, nextpc, nextpc + 10'd1, ins_of(nextpc), ins_of(nextpc + 10'd1), ic, fl, p);
        nextpc += 10'(p);
    endtask

    task automatic pop_cmp(input string slot, input logic [9:0] pc, input logic [31:0] instr);
        entry_t e;
        if (sb.size() == 0) chk({"issue_unexpected_", slot}, 1, 0);
        else begin
            e = sb.pop_front();
            chk({"issue_pc_", slot}, 64'(pc), 64'(e.pc));
            chk({"issue_instr_", slot}, 64'(instr), 64'(e.instr));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid_1 && issue_count >= 2'd1) pop_cmp("1", out_pc_1, out_instr_1);
            if (out_valid_2 && issue_count == 2'd2) pop_cmp("2", out_pc_2, out_instr_2);
        end
    end

    initial begin
        int p;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_state();
        @(posedge clk);
        #1 rst = 0;

        step(1, 1, 10'd10, 10'd11, 32'h20080005, 32'h20090003, 2'd0, 0, p);
        step(0, 0, 0, 0, 0, 0, 2'd2, 0, p);
        gen(0, 0, 0, 0);

        repeat (5) gen(1, 1, 0, 0);
        gen(0, 0, 0, 0);
        repeat (4) gen(0, 0, 2, 0);

        nextpc = 10'd40;
        gen(1, 0, 0, 0);
        gen(0, 0, 2, 0);
        gen(0, 1, 0, 0);
        gen(0, 0, 0, 0);

        nextpc = 10'd1018;
        repeat (10) gen(1, 1, 1, 0);
        repeat (10) gen(1, 0, 2, 0);
        repeat (DEPTH) gen(0, 0, 2, 0);

        gen(1, 1, 0, 0);
        gen(1, 1, 0, 0);
        gen(1, 0, 0, 0);
        gen(1, 1, 1, 1);
        gen(0, 0, 0, 0);

        repeat (3) gen(1, 1, 0, 0);
        rst = 1;
        mcount = 0;
        sb.delete();
        @(negedge clk);
        check_state();
        @(posedge clk);
        #1 rst = 0;
        gen(0, 0, 0, 0);

        repeat (400)
            gen($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                2'($urandom_range(0, 2)), $urandom_range(0, 31) == 0);

        for (int k = 0; k < DEPTH + 2 && mcount > 0; k++) gen(0, 0, 2, 0);
        gen(0, 0, 0, 0);
        chk("scoreboard_drained", 64'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_issue_buffer.md
# fetch_issue_buffer

Decoupling queue between the dual-issue fetch stage and the decode/issue stage. Accepts zero, one or two instructions per cycle from fetch, together with their PCs, and presents the two oldest entries to decode in program order. It raises `hold` back to fetch when it cannot accept a full pair, and discards its whole contents on a branch-correction flush.

## Interface
Parameters:
- `DEPTH`, 8: number of entries; a power of two, at least 4.
- `PC_W`, 10: PC/address width.
- `INSTR_W`, 32: instruction width.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  correction flush (driven with fetch `correct_en`); empties the queue.
- `in_valid_1`  in  1  slot-1 instruction from fetch is valid.
- `in_valid_2`  in  1  slot-2 valid (fetch drives `!flush_second`); ignored unless `in_valid_1`.
- `in_instr_1`, `in_instr_2`  in  INSTR_W  fetched instructions.
- `in_pc_1`, `in_pc_2`  in  PC_W  PCs of the fetched instructions.
- `hold`  out  1  back-pressure to fetch; combinational.
- `issue_count`  in  2  number of head entries decode consumes this cycle (0..2).
- `out_valid_1`, `out_valid_2`  out  1  head and head+1 entries valid.
- `out_instr_1`, `out_instr_2`  out  INSTR_W  head and head+1 instructions; 0 (NOP) when not valid.
- `out_pc_1`, `out_pc_2`  out  PC_W  head and head+1 PCs; 0 when not valid.
- `count`  out  $clog2(DEPTH)+1  current occupancy, for debug and performance counters.

## Operation
- State: storage array of {pc, instr}, `head` and `tail` pointers of $clog2(DEPTH) bits, and `count`.
- Pointers wrap modulo DEPTH; because DEPTH is a power of two, natural overflow provides the wrap.
- Push amount: `push` = 0 if `hold` or `flush`; else 2 if `in_valid_1 && in_valid_2`; else 1 if `in_valid_1`; else 0.
- Slot 1 is written at `tail` and slot 2 at `tail+1`.
- `in_valid_2` without `in_valid_1` pushes nothing.
- `hold` = (`count` > DEPTH−2), computed from the registered count.
  - Fetch holds its PC while `hold` is high and re-presents the same pair, so a dropped push loses nothing.
- Pop amount: `pop` = min(`issue_count`, `count`). Over-request is clamped and is not an error.
  - `issue_count`=2 with `out_valid_2`=0 pops one entry.
- Show-ahead output: `out_*_1` comes from `head`, `out_*_2` from `head+1`; both are combinational from storage and pointers.
- `out_valid_1` = (`count` ≥ 1); `out_valid_2` = (`count` ≥ 2).
- Update rules: `count_next` = `count` + `push` − `pop`; `head` += `pop`; `tail` += `push`.
- Simultaneous push and pop in the same cycle is legal. Pop uses entries present before the edge, so a pushed entry is never visible at the outputs in the same cycle.
- Push while full cannot occur: `hold` is asserted when fewer than 2 entries are free.
- Flush: at the next edge `head`, `tail` and `count` become 0. Same-cycle push and pop are discarded and flush wins. Storage contents are left unchanged.

## Timing
- Reset (asynchronous assert): `head`=`tail`=`count`=0.
  - Resulting outputs: `out_valid_1`/`out_valid_2`=0, `out_instr_*`=0, `out_pc_*`=0, `hold`=0.
  - Storage need not be reset.
- Reset deasserting mid-operation takes effect on the next rising edge with an empty queue.
- Latency: an instruction pushed at edge N appears at the outputs after edge N if the queue was empty. Minimum fill-to-issue latency is one cycle.
- `hold` changes only after a clock edge; it has no combinational path from `in_*` or `issue_count`.
- Throughput: sustains 2 pushes and 2 pops per cycle indefinitely when occupancy stays between 2 and DEPTH−2.

## Structure
- Shared package `fetch_buffer_pkg` holds:
  - `NOP_INSTR` = 32'h0;
  - the entry struct/typedef {pc, instr};
  - the default DEPTH;
  - the `pop` clamp helper function.
- One sub-module, `fb_storage`: a DEPTH-entry register file with two write ports (`tail`, `tail+1`) and two asynchronous read ports (`head`, `head+1`).
- Pointer, count and hold logic stay in the top module.

## Test plan
- Reset then idle: after `rst` pulse, `count`=0, `out_valid_1`=0, `out_instr_1`=0, `hold`=0.
- Pair push then pop:
  - push {pc 10, 32'h20080005} / {pc 11, 32'h20090003} with `issue_count`=0;
  - next cycle `out_pc_1`=10, `out_pc_2`=11, `count`=2;
  - `issue_count`=2 → `count`=0.
- Fill to hold with DEPTH=8: push pairs for 4 cycles with no issue.
  - After the 3rd edge `count`=6 and `hold`=0.
  - After the 4th edge `count`=8 and `hold`=1.
  - A further push is dropped and `count` stays 8.
- Clamp and odd push:
  - push slot 1 only (pc 40), giving `count`=1;
  - `issue_count`=2 → `count`=0 and no underflow.
  - push with `in_valid_2`=1, `in_valid_1`=0 → `count` unchanged.
- Wrap-around: run continuous 2-in/1-out then 1-in/2-out for 20 cycles with sequential PCs 0..N. Outputs must stay in strict PC order across the pointer wrap.
- Flush priority:
  - with `count`=5, assert `flush` together with a pair push and `issue_count`=1;
  - next cycle `count`=0, both valids 0, `hold`=0.
